// File: rtl/piece_queue_pkg.sv
// Shared defaults, LFSR tap mask and FSM state type for the next-piece queue.
package piece_queue_pkg;

  localparam int          DEF_PIECE_W    = 3;
  localparam int          DEF_NUM_PIECES = 7;
  localparam logic [15:0] DEF_SEED       = 16'hACE1;

  // Galois form of x^16 + x^14 + x^13 + x^11 + 1, shifting toward bit 0.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/piece_queue_if.sv
// Command/status bundle between the game-control FSM (master) and piece_queue (slave).
interface piece_queue_if
  import piece_queue_pkg::*;
#(
  parameter int PIECE_W = DEF_PIECE_W,
  parameter int DEPTH   = 5
);

  logic                         advance;
  logic                         swap;
  logic                         ready;
  logic [PIECE_W-1:0]           current;
  logic [(DEPTH-1)*PIECE_W-1:0] preview;
  logic [PIECE_W-1:0]           hold;
  logic                         hold_valid;
  logic                         swap_ok;

  modport master (
    output advance, swap,
    input  ready, current, preview, hold, hold_valid, swap_ok
  );

  modport slave (
    input  advance, swap,
    output ready, current, preview, hold, hold_valid, swap_ok
  );

endinterface

// File: rtl/piece_lfsr.sv
// Free-running 16-bit Galois LFSR whose low bits are folded into the legal piece range.
module piece_lfsr
  import piece_queue_pkg::*;
#(
  parameter int          PIECE_W    = DEF_PIECE_W,
  parameter int          NUM_PIECES = DEF_NUM_PIECES,
  parameter logic [15:0] SEED       = DEF_SEED
) (
  input  logic               clk,
  input  logic               reset_n,
  output logic [PIECE_W-1:0] piece
);

  localparam logic [PIECE_W:0] NUM_EXT = (PIECE_W + 1)'(NUM_PIECES);

  logic [15:0]        lfsr;
  logic [PIECE_W-1:0] raw;

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lfsr <= SEED;
    end else begin
      lfsr <= (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
    end
  end

  assign raw   = lfsr[PIECE_W-1:0];
  // Single subtraction: maps the raw values just past the range back onto the low codes.
  assign piece = ({1'b0, raw} >= NUM_EXT) ? raw - NUM_EXT[PIECE_W-1:0] : raw;

endmodule

// File: rtl/piece_queue.sv
// Next-piece queue with LFSR refill and optional hold slot.
// Hold slot and swap logic are built only when PIECE_QUEUE_HOLD_EN is defined.
module piece_queue
  import piece_queue_pkg::*;
#(
  parameter int          PIECE_W    = DEF_PIECE_W,
  parameter int          DEPTH      = 5,
  parameter int          NUM_PIECES = DEF_NUM_PIECES,
  parameter logic [15:0] SEED       = DEF_SEED
) (
  input  logic          clk,
  input  logic          reset_n,
  piece_queue_if.slave  bus
);

  localparam int                CNT_W     = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(DEPTH - 1);

  state_t                        state, state_next;
  logic [CNT_W-1:0]              fill_cnt;
  logic [DEPTH-1:0][PIECE_W-1:0] slots;
  logic [PIECE_W-1:0]            new_piece;
  logic                          do_shift;

`ifdef PIECE_QUEUE_HOLD_EN
  logic [PIECE_W-1:0] hold_q;
  logic               hold_valid_q;
  logic               swap_used;
  logic               swap_ok;
  logic               take_hold;
  logic               exchange;
  logic               set_used;
  logic               clr_used;
`endif

  piece_lfsr #(
    .PIECE_W    (PIECE_W),
    .NUM_PIECES (NUM_PIECES),
    .SEED       (SEED)
  ) u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .piece   (new_piece)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= FILL;
      fill_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == FILL && fill_cnt != FILL_LAST) begin
        fill_cnt <= fill_cnt + 1'b1;
      end
    end
  end

`ifdef PIECE_QUEUE_HOLD_EN
  assign swap_ok = (state == RUN) && !swap_used;
`endif

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    do_shift   = 1'b0;
`ifdef PIECE_QUEUE_HOLD_EN
    take_hold  = 1'b0;
    exchange   = 1'b0;
    set_used   = 1'b0;
    clr_used   = 1'b0;
`endif
    unique case (state)
      FILL: begin
        do_shift = 1'b1;
        if (fill_cnt == FILL_LAST) state_next = RUN;
      end
      RUN: begin
        // advance has priority; a simultaneous swap is dropped.
        if (bus.advance) begin
          do_shift = 1'b1;
`ifdef PIECE_QUEUE_HOLD_EN
          clr_used = 1'b1;
        end else if (bus.swap && swap_ok) begin
          set_used = 1'b1;
          if (hold_valid_q) begin
            exchange = 1'b1;
          end else begin
            take_hold = 1'b1;
            do_shift  = 1'b1;
          end
`endif
        end
      end
    endcase
  end

  // NOTE: the slot array is small and architecturally visible, so it is reset like any register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      slots <= '0;
    end else if (do_shift) begin
      slots <= {new_piece, slots[DEPTH-1:1]};
`ifdef PIECE_QUEUE_HOLD_EN
    end else if (exchange) begin
      slots[0] <= hold_q;
`endif
    end
  end

`ifdef PIECE_QUEUE_HOLD_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      swap_used    <= 1'b0;
    end else begin
      if (take_hold || exchange) hold_q <= slots[0];
      if (take_hold) hold_valid_q <= 1'b1;
      if (clr_used) begin
        swap_used <= 1'b0;
      end else if (set_used) begin
        swap_used <= 1'b1;
      end
    end
  end

  assign bus.hold       = hold_q;
  assign bus.hold_valid = hold_valid_q;
  assign bus.swap_ok    = swap_ok;
`else
  logic unused_swap;
  assign unused_swap    = bus.swap;
  assign bus.hold       = '0;
  assign bus.hold_valid = 1'b0;
  assign bus.swap_ok    = 1'b0;
`endif

  assign bus.ready   = (state == RUN);
  assign bus.current = slots[0];
  assign bus.preview = slots[DEPTH-1:1];

endmodule

// File: tb/tb_piece_queue.sv
// Directed, table-driven bench for piece_queue (default and DEPTH=3/PIECE_W=4 instances).
module tb_piece_queue;

  logic clk;
  logic rst_n;
  logic rst_s;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef PIECE_QUEUE_HOLD_EN
  localparam bit HOLD_BUILT = 1'b1;
`else
  localparam bit HOLD_BUILT = 1'b0;
`endif

  piece_queue_if #(.PIECE_W(3), .DEPTH(5)) bus   ();
  piece_queue_if #(.PIECE_W(4), .DEPTH(3)) bus_s ();

  piece_queue #(.PIECE_W(3), .DEPTH(5), .NUM_PIECES(7), .SEED(16'hACE1)) u_dut (
    .clk     (clk),
    .reset_n (rst_n),
    .bus     (bus.slave)
  );

  piece_queue #(.PIECE_W(4), .DEPTH(3), .NUM_PIECES(7), .SEED(16'hACE1)) u_dut_s (
    .clk     (clk),
    .reset_n (rst_s),
    .bus     (bus_s.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic            r;
    logic            adv;
    logic            swp;
    logic [4:0][2:0] q;
    logic [2:0]      hold;
    logic            hv;
    logic            rdy;
    logic            ok;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  function automatic vec_t mk(bit r, bit a, bit s, int c0, int c1, int c2, int c3, int c4,
                              int h, bit hv, bit rdy, bit ok);
    vec_t v;
    v.r    = r;
    v.adv  = a;
    v.swp  = s;
    v.q[0] = 3'(c0);
    v.q[1] = 3'(c1);
    v.q[2] = 3'(c2);
    v.q[3] = 3'(c3);
    v.q[4] = 3'(c4);
    v.hold = 3'(h);
    v.hv   = hv;
    v.rdy  = rdy;
    v.ok   = ok;
    return v;
  endfunction

  function automatic logic [15:0] lfsr_step(logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  function automatic int fold3(logic [15:0] s);
    int r;
    r = int'(s[2:0]);
    return (r >= 7) ? r - 7 : r;
  endfunction

  initial begin
    logic [15:0] ms;
    int          m [5];
    int          exp_pre;

    rst_n         = 1'b0;
    rst_s         = 1'b0;
    bus.advance   = 1'b0;
    bus.swap      = 1'b0;
    bus_s.advance = 1'b0;
    bus_s.swap    = 1'b0;

    // Folded LFSR stream from SEED: 1,0,0,4,6,0,3,1,4,2,1,0,4,6,3,5,2,...
    //             r  a  s   slot0..slot4     hold hv rdy ok
    vecs.push_back(mk(0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1,  0, 0, 0, 0, 0,  0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0,  0, 0, 0, 0, 1,  0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0,  0, 0, 0, 1, 0,  0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1,  0, 0, 1, 0, 0,  0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0,  0, 1, 0, 0, 4,  0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0,  1, 0, 0, 4, 6,  0, 0, 1, HOLD_BUILT));
    vecs.push_back(mk(1, 0, 0,  1, 0, 0, 4, 6,  0, 0, 1, HOLD_BUILT));
    vecs.push_back(mk(1, 1, 0,  0, 0, 4, 6, 3,  0, 0, 1, HOLD_BUILT));
    vecs.push_back(mk(1, 1, 0,  0, 4, 6, 3, 1,  0, 0, 1, HOLD_BUILT));
    vecs.push_back(mk(1, 1, 0,  4, 6, 3, 1, 4,  0, 0, 1, HOLD_BUILT));
`ifdef PIECE_QUEUE_HOLD_EN
    vecs.push_back(mk(1, 0, 1,  6, 3, 1, 4, 2,  4, 1, 1, 0));
    vecs.push_back(mk(1, 0, 1,  6, 3, 1, 4, 2,  4, 1, 1, 0));
    vecs.push_back(mk(1, 1, 0,  3, 1, 4, 2, 0,  4, 1, 1, 1));
    vecs.push_back(mk(1, 0, 1,  4, 1, 4, 2, 0,  3, 1, 1, 0));
    vecs.push_back(mk(1, 1, 1,  1, 4, 2, 0, 6,  3, 1, 1, 1));
    vecs.push_back(mk(1, 0, 1,  3, 4, 2, 0, 6,  1, 1, 1, 0));
    vecs.push_back(mk(1, 1, 0,  4, 2, 0, 6, 5,  1, 1, 1, 1));
    vecs.push_back(mk(1, 1, 0,  2, 0, 6, 5, 2,  1, 1, 1, 1));
`else
    vecs.push_back(mk(1, 0, 1,  4, 6, 3, 1, 4,  0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 1,  4, 6, 3, 1, 4,  0, 0, 1, 0));
    vecs.push_back(mk(1, 1, 0,  6, 3, 1, 4, 0,  0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 1,  6, 3, 1, 4, 0,  0, 0, 1, 0));
    vecs.push_back(mk(1, 1, 1,  3, 1, 4, 0, 6,  0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 1,  3, 1, 4, 0, 6,  0, 0, 1, 0));
    vecs.push_back(mk(1, 1, 0,  1, 4, 0, 6, 5,  0, 0, 1, 0));
    vecs.push_back(mk(1, 1, 0,  4, 0, 6, 5, 2,  0, 0, 1, 0));
`endif
    vecs.push_back(mk(0, 1, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0,  0, 0, 0, 0, 1,  0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0,  0, 0, 0, 1, 0,  0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0,  0, 0, 1, 0, 0,  0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0,  0, 1, 0, 0, 4,  0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0,  1, 0, 0, 4, 6,  0, 0, 1, HOLD_BUILT));

    for (int i = 0; i < vecs.size(); i++) begin
      rst_n       = vecs[i].r;
      bus.advance = vecs[i].adv;
      bus.swap    = vecs[i].swp;
      @(posedge clk);
      #1;
      exp_pre = int'({vecs[i].q[4], vecs[i].q[3], vecs[i].q[2], vecs[i].q[1]});
      check($sformatf("v%0d current", i),    int'(bus.current),    int'(vecs[i].q[0]));
      check($sformatf("v%0d preview", i),    int'(bus.preview),    exp_pre);
      check($sformatf("v%0d hold", i),       int'(bus.hold),       int'(vecs[i].hold));
      check($sformatf("v%0d hold_valid", i), int'(bus.hold_valid), int'(vecs[i].hv));
      check($sformatf("v%0d ready", i),      int'(bus.ready),      int'(vecs[i].rdy));
      check($sformatf("v%0d swap_ok", i),    int'(bus.swap_ok),    int'(vecs[i].ok));
    end
    bus.advance = 1'b0;
    bus.swap    = 1'b0;

    // Independent software LFSR model for the post-reset fill contents.
    ms = 16'hACE1;
    for (int k = 0; k < 5; k++) begin
      m[k] = fold3(ms);
      ms   = lfsr_step(ms);
    end
    check("model current", int'(bus.current), m[0]);
    check("model preview", int'(bus.preview), (m[4] << 9) | (m[3] << 6) | (m[2] << 3) | m[1]);

    // Reduced instance: DEPTH=3, PIECE_W=4. Raw nibbles 1,0,8,C fold to 1,0,1,5.
    @(posedge clk);
    #1;
    check("small reset current", int'(bus_s.current), 0);
    check("small reset ready",   int'(bus_s.ready),   0);
    rst_s = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("small fill%0d ready", k), int'(bus_s.ready), (k == 2) ? 1 : 0);
    end
    check("small fill current", int'(bus_s.current), 1);
    check("small fill preview", int'(bus_s.preview), 8'h10);

    bus_s.advance = 1'b1;
    @(posedge clk);
    #1;
    bus_s.advance = 1'b0;
    check("small adv current", int'(bus_s.current), 0);
    check("small adv preview", int'(bus_s.preview), 8'h51);

`ifndef PIECE_QUEUE_HOLD_EN
    bus_s.swap = 1'b1;
    @(posedge clk);
    #1;
    bus_s.swap = 1'b0;
    check("small swap current",    int'(bus_s.current),    0);
    check("small swap preview",    int'(bus_s.preview),    8'h51);
    check("small swap hold",       int'(bus_s.hold),       0);
    check("small swap hold_valid", int'(bus_s.hold_valid), 0);
    check("small swap swap_ok",    int'(bus_s.swap_ok),    0);
`endif

    check("small range current", int'(bus_s.current < 4'd7), 1);
    check("small range slot1",   int'(bus_s.preview[3:0] < 4'd7), 1);
    check("small range slot2",   int'(bus_s.preview[7:4] < 4'd7), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
